// File: rtl/cdc_xfer_arbiter.sv
// Source-side scheduler for one 4-phase CDC data channel: round-robin pick,
// freeze the winner's tagged word, sequence valid/ack, recover from a lost ack.
//   state   | meaning
//   IDLE    | no transfer; grant when a request is pending and cdc_ack is low
//   SEND    | cdc_valid high, cdc_data frozen, waiting for cdc_ack to rise
//   RELEASE | cdc_valid low, waiting for cdc_ack to fall
module cdc_xfer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*DATA_W-1:0]            req_data,
    output logic [NUM_REQ-1:0]                   req_ack,
    output logic [NUM_REQ-1:0]                   req_done,
    output logic                                 cdc_valid,
    output logic [$clog2(NUM_REQ)+DATA_W-1:0]    cdc_data,
    input  logic                                 cdc_ack,
    input  logic                                 err_clr,
    output logic                                 err_timeout,
    output logic                                 busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t                    state, state_nxt;
    logic [ID_W-1:0]           ptr, ptr_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt, cnt_inc;
    logic                      cnt_hit;
    logic                      found;
    logic [ID_W-1:0]           win, cand;
    logic [DATA_W-1:0]         words [NUM_REQ];
    logic [NUM_REQ-1:0]        ack_nxt, done_nxt;
    logic                      valid_nxt, err_nxt, busy_nxt;
    logic [ID_W+DATA_W-1:0]    data_nxt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = req_data[g*DATA_W +: DATA_W];
    end

    assign cnt_inc = cnt + CNT_W'(1);
    // The ack edge has to arrive within TIMEOUT cycles of entering the wait state.
    assign cnt_hit = (TIMEOUT > 0) && (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            cnt         <= '0;
            req_ack     <= '0;
            req_done    <= '0;
            cdc_valid   <= 1'b0;
            cdc_data    <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            req_ack     <= ack_nxt;
            req_done    <= done_nxt;
            cdc_valid   <= valid_nxt;
            cdc_data    <= data_nxt;
            err_timeout <= err_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found && !cdc_ack) state_nxt = SEND;
            SEND:    if (cdc_ack) state_nxt = RELEASE;
                     else if (cnt_hit) state_nxt = IDLE;
            RELEASE: if (!cdc_ack || cnt_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt = cdc_valid;
        data_nxt  = cdc_data;
        ack_nxt   = '0;
        done_nxt  = '0;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt_inc;
        err_nxt   = err_timeout & ~err_clr;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (found && !cdc_ack) begin
                    valid_nxt    = 1'b1;
                    data_nxt     = {win, words[win]};
                    ack_nxt[win] = 1'b1;
                    ptr_nxt      = win;
                end
            end
            SEND: begin
                if (cdc_ack) begin
                    valid_nxt     = 1'b0;
                    done_nxt[ptr] = 1'b1;
                    cnt_nxt       = '0;
                end else if (cnt_hit) begin
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b1;
                end
            end
            RELEASE: begin
                if (!cdc_ack) cnt_nxt = '0;
                else if (cnt_hit) err_nxt = 1'b1;
            end
            default: cnt_nxt = '0;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed bench for cdc_xfer_arbiter: table of single transfers plus
// hand sequences for held requests, timeout, stale ack and async reset.
module tb_cdc_xfer_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ack, req_done;
    logic              cdc_valid;
    logic [17:0]       cdc_data;
    logic              cdc_ack;
    logic              err_clr = 1'b0;
    logic              err_timeout, busy;

    logic [DW-1:0]     words [NR];
    int                ack_mode = 0;   // 0 echo valid after 2 cycles, 1 stuck low, 2 stuck high
    logic [1:0]        pipe = 2'b00;
    int                total = 0;
    int                bad = 0;

    typedef struct {
        logic [NR-1:0] pat;
        int            idx;
    } vec_t;
    vec_t vecs [10];

    cdc_xfer_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_data(req_data),
        .req_ack(req_ack), .req_done(req_done), .cdc_valid(cdc_valid),
        .cdc_data(cdc_data), .cdc_ack(cdc_ack), .err_clr(err_clr),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        case (ack_mode)
            0:       cdc_ack = pipe[1];
            1:       cdc_ack = 1'b0;
            default: cdc_ack = 1'b1;
        endcase
        pipe = {pipe[0], cdc_valid};
    end

    assign req_data = {words[3], words[2], words[1], words[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int i);
        logic [1:0] id;
        id = i[1:0];
        return {14'b0, id, words[i]};
    endfunction

    task automatic wait_ack();
        int n = 0;
        @(negedge clk);
        while (req_ack == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (req_done == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic xfer(input logic [NR-1:0] pat, input int idx, input string tag);
        ack_mode = 0;
        req = pat;
        wait_ack();
        req = '0;
        chk({tag, "_ack"}, 32'(req_ack), 32'(1 << idx));
        chk({tag, "_data"}, 32'(cdc_data), exp_data(idx));
        chk({tag, "_valid"}, 32'(cdc_valid), 32'd1);
        @(negedge clk);
        chk({tag, "_ack_width"}, 32'(req_ack), 32'd0);
        wait_done();
        chk({tag, "_done"}, 32'(req_done), 32'(1 << idx));
        wait_idle();
        chk({tag, "_idle"}, 32'({busy, cdc_valid}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        words[0] = 16'hA5A5;
        words[1] = 16'h1B1B;
        words[2] = 16'h2C2C;
        words[3] = 16'h3D3D;

        vecs[0] = '{4'b0001, 0};
        vecs[1] = '{4'b1111, 1};
        vecs[2] = '{4'b1001, 3};
        vecs[3] = '{4'b1001, 0};
        vecs[4] = '{4'b0110, 1};
        vecs[5] = '{4'b0101, 2};
        vecs[6] = '{4'b0011, 0};
        vecs[7] = '{4'b1000, 3};
        vecs[8] = '{4'b0100, 2};
        vecs[9] = '{4'b0100, 2};

        repeat (3) @(negedge clk);
        chk("rst_outputs", {10'b0, req_ack, req_done, cdc_valid, err_timeout, busy},
            32'd0);
        chk("rst_data", 32'(cdc_data), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            xfer(vecs[i].pat, vecs[i].idx, $sformatf("vec%0d", i));
        repeat (3) @(negedge clk);
        chk("data_held", 32'(cdc_data), exp_data(2));

        // Held requests rotate 3,0,1,2,3 from pointer 2.
        ack_mode = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack();
            if (k == 4) req = '0;
            chk($sformatf("rr%0d_ack", k), 32'(req_ack), 32'(1 << ((3 + k) % 4)));
            chk($sformatf("rr%0d_data", k), 32'(cdc_data), exp_data((3 + k) % 4));
            wait_done();
            chk($sformatf("rr%0d_done", k), 32'(req_done), 32'(1 << ((3 + k) % 4)));
            chk($sformatf("rr%0d_valid_low", k), 32'(cdc_valid), 32'd0);
        end
        wait_idle();

        // Timeout with err_clr held: set wins over clear.
        ack_mode = 1;
        err_clr = 1'b1;
        req = 4'b0010;
        wait_ack();
        req = '0;
        chk("to_ack", 32'(req_ack), 32'b0010);
        n = 0;
        seen = 1'b0;
        while (cdc_valid && n < 20) begin
            @(negedge clk);
            n++;
            seen = seen | (req_done != '0);
        end
        chk("to_valid_cycles", 32'(n), 32'd8);
        chk("to_err_set", 32'(err_timeout), 32'd1);
        chk("to_no_done", 32'(seen), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_err_sticky", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_err_clr", 32'(err_timeout), 32'd0);

        // Stale ack high: nothing granted until it drops.
        ack_mode = 2;
        req = 4'b0010;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | (req_ack != '0) | busy;
        end
        chk("stale_no_grant", 32'(seen), 32'd0);
        xfer(4'b0010, 1, "stale");

        // Async reset in SEND.
        ack_mode = 1;
        req = 4'b0001;
        wait_ack();
        req = '0;
        chk("ar_ack", 32'(req_ack), 32'b0001);
        repeat (2) @(negedge clk);
        chk("ar_in_send", 32'({busy, cdc_valid}), 32'b11);
        #2 resetn = 1'b0;
        #1;
        chk("ar_async_clear", 32'({busy, cdc_valid}), 32'd0);
        chk("ar_data_clear", 32'(cdc_data), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        xfer(4'b1111, 0, "ar_first");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
